// File: rtl/spi_flash_responder_pkg.sv
// rtl/spi_flash_responder_pkg.sv - shared types and constants for the SPI flash responder (honours SPI_FLASH_FAST_READ_EN)
package spi_flash_responder_pkg;

  localparam int          ADDR_W       = 24;
  localparam logic [7:0]  OP_READ      = 8'h03;
  localparam logic [7:0]  OP_FAST_READ = 8'h0B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_IGNORE
  } state_t;

  // Opcodes this build of the responder will serve; everything else is ignored.
  function automatic logic op_supported(input logic [7:0] op);
`ifdef SPI_FLASH_FAST_READ_EN
    return (op == OP_READ) || (op == OP_FAST_READ);
`else
    return (op == OP_READ);
`endif
  endfunction

endpackage

// File: rtl/spi_flash_responder_edge_sync.sv
// rtl/spi_flash_responder_edge_sync.sv - spi_edge_sync: SPI pin synchronizers and sclk edge pulses
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic i_sclk,
  input  logic i_cs,
  input  logic i_mosi,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_cs,
  output logic o_cs_fall,
  output logic o_mosi
);

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic                   r_cs_d;
  logic [SYNC_STAGES:0]   r_fill;

  logic w_sclk;
  logic w_cs;

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs   = r_cs_sync[SYNC_STAGES-1];

  // Synchronizer chains plus one history flop per edge-detected signal.
  // r_fill marks when the chains hold only post-reset samples, so a cs that
  // was already low across reset is not mistaken for a fresh select.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
      r_fill      <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_sclk_d    <= w_sclk;
      r_cs_d      <= w_cs;
      r_fill      <= {r_fill[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign o_sclk_rise = w_sclk & ~r_sclk_d;
  assign o_sclk_fall = ~w_sclk & r_sclk_d;
  assign o_cs        = w_cs;
  assign o_cs_fall   = r_fill[SYNC_STAGES] & r_cs_d & ~w_cs;
  assign o_mosi      = r_mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_flash_responder.sv
// rtl/spi_flash_responder.sv - mode-0 SPI flash read responder; SPI_FLASH_FAST_READ_EN adds opcode 0x0B
module spi_flash_responder
  import spi_flash_responder_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_spi_clk,
  input  logic              io_spi_cs,
  input  logic              io_spi_mosi,
  output logic              io_spi_miso,
  output logic              io_rd_req,
  output logic [ADDR_W-1:0] io_rd_addr,
  input  logic [7:0]        io_rd_data,
  output logic              io_cmd_err
);

  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs;
  logic w_cs_fall;
  logic w_mosi;

  spi_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clock       (clock),
    .reset       (reset),
    .i_sclk      (io_spi_clk),
    .i_cs        (io_spi_cs),
    .i_mosi      (io_spi_mosi),
    .o_sclk_rise (w_sclk_rise),
    .o_sclk_fall (w_sclk_fall),
    .o_cs        (w_cs),
    .o_cs_fall   (w_cs_fall),
    .o_mosi      (w_mosi)
  );

  state_t            r_state;
  logic [4:0]        r_bit_cnt;
  logic [7:0]        r_cmd_shift;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_tx_shift;
  logic              r_fast;
  logic              r_load_pend;
  logic              r_rd_req;
  logic              r_cmd_err;
  logic              r_miso;

  logic [7:0]        w_op;
  logic [ADDR_W-1:0] w_addr_next;

  assign w_op        = {r_cmd_shift[6:0], w_mosi};
  assign w_addr_next = {r_addr[ADDR_W-2:0], w_mosi};

  // Transaction FSM: command/address/dummy shifting, read strobes and miso.
  // The store answers one cycle after io_rd_req, so the byte is captured two
  // edges after the strobe, well before the next detected sclk fall.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_cmd_shift <= '0;
      r_addr      <= '0;
      r_tx_shift  <= '0;
      r_fast      <= 1'b0;
      r_load_pend <= 1'b0;
      r_rd_req    <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_miso      <= 1'b1;
    end else begin
      r_rd_req    <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_load_pend <= r_rd_req;

      if (r_load_pend) begin
        r_tx_shift <= io_rd_data;
      end else if (r_state == ST_DATA && w_sclk_fall) begin
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end

      if (w_cs) begin
        // Deselect aborts whatever is in flight, including a pending load.
        r_state     <= ST_IDLE;
        r_bit_cnt   <= '0;
        r_miso      <= 1'b1;
        r_load_pend <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_miso <= 1'b1;
            if (w_cs_fall) begin
              r_state     <= ST_CMD;
              r_bit_cnt   <= '0;
              r_cmd_shift <= '0;
              r_fast      <= 1'b0;
            end
          end

          ST_CMD: begin
            if (w_sclk_rise) begin
              r_cmd_shift <= w_op;
              if (r_bit_cnt == 5'd7) begin
                r_bit_cnt <= '0;
                if (op_supported(w_op)) begin
                  r_state <= ST_ADDR;
                  r_fast  <= (w_op == OP_FAST_READ);
                end else begin
                  r_state   <= ST_IGNORE;
                  r_cmd_err <= 1'b1;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end

          ST_ADDR: begin
            if (w_sclk_rise) begin
              r_addr <= w_addr_next;
              if (r_bit_cnt == 5'd23) begin
                r_bit_cnt <= '0;
                if (r_fast) begin
                  r_state <= ST_DUMMY;
                end else begin
                  r_state  <= ST_DATA;
                  r_rd_req <= 1'b1;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end

          ST_DUMMY: begin
            if (w_sclk_rise) begin
              if (r_bit_cnt == 5'd7) begin
                r_bit_cnt <= '0;
                r_state   <= ST_DATA;
                r_rd_req  <= 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end

          ST_DATA: begin
            if (w_sclk_fall) begin
              r_miso <= r_tx_shift[7];
            end
            if (w_sclk_rise) begin
              if (r_bit_cnt == 5'd7) begin
                // Byte complete: fetch the next one; address wraps at the top.
                r_bit_cnt <= '0;
                r_addr    <= r_addr + 24'd1;
                r_rd_req  <= 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end

          ST_IGNORE: begin
            r_miso <= 1'b1;
          end

          default: begin
            r_state <= ST_IDLE;
            r_miso  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign io_spi_miso = r_miso;
  assign io_rd_req   = r_rd_req;
  assign io_rd_addr  = r_addr;
  assign io_cmd_err  = r_cmd_err;

endmodule
